// File: rtl/ht1080z_cas_pkg.sv
// Shared types and constants for the HT1080Z cassette-capture / HPS-upload block.
package ht1080z_cas_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRecord = 2'd1,
        StHold   = 2'd2,
        StUpload = 2'd3
    } cas_state_e;

    localparam int unsigned CAS_DEPTH_LOG2_DEF = 15;
    localparam logic [7:0]  CAS_PAD_BYTE       = 8'h00;

endpackage

// File: rtl/ht1080z_cas_ram.sv
// Simple dual-port tape buffer: one write port, one registered read port, no reset.
module ht1080z_cas_ram #(
    parameter int unsigned AW = 15
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [2**AW];
    logic [7:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ht1080z_cas_upload.sv
// Records cassette-out bytes while the motor relay is on, then serves them to the HPS
// as an upload file with a two-cycle read latency.
module ht1080z_cas_upload
    import ht1080z_cas_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = CAS_DEPTH_LOG2_DEF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        cas_motor,
    input  logic [7:0]  cas_byte,
    input  logic        cas_byte_valid,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [15:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic [15:0] cas_len,
    output logic        rec_active,
    output logic        overflow,
    output logic        tape_ready
);

    localparam logic [DEPTH_LOG2:0] PtrOne = 1;

    cas_state_e          r_state;
    cas_state_e          w_state_next;
    logic                r_motor_d;
    logic                r_upload_d;
    logic                r_primed;
    logic [DEPTH_LOG2:0] r_ptr;
    logic                r_overflow;
    logic                r_rd_pend;
    logic                r_rd_ok;
    logic [7:0]          r_din;
    logic [7:0]          w_ram_q;
    logic                w_motor_rise;
    logic                w_motor_fall;
    logic                w_upload_rise;
    logic                w_upload_fall;
    logic                w_full;
    logic                w_wr_en;
    logic                w_drop;
    logic                w_clear;
    logic                w_rd_ok;

    // r_primed masks the first sample after reset so a level already high is not an edge.
    assign w_motor_rise  = r_primed & cas_motor & ~r_motor_d;
    assign w_motor_fall  = r_primed & ~cas_motor & r_motor_d;
    assign w_upload_rise = r_primed & ioctl_upload & ~r_upload_d;
    assign w_upload_fall = r_primed & ~ioctl_upload & r_upload_d;

    assign w_full  = r_ptr[DEPTH_LOG2];
    assign w_wr_en = (r_state == StRecord) & cas_byte_valid & ~w_full;
    assign w_drop  = (r_state == StRecord) & cas_byte_valid & w_full;
    assign cas_len = 16'(r_ptr);
    assign w_rd_ok = ioctl_rd & (r_state == StUpload) & (ioctl_addr < cas_len);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_motor_rise) begin
                    w_state_next = StRecord;
                    w_clear      = 1'b1;
                end
            end
            StRecord: begin
                // A byte landing on the falling edge still counts toward a non-empty tape.
                if (w_motor_fall) begin
                    w_state_next = ((r_ptr != '0) || w_wr_en) ? StHold : StIdle;
                end
            end
            StHold: begin
                if (w_upload_rise) begin
                    w_state_next = StUpload;
                end else if (w_motor_rise) begin
                    w_state_next = StRecord;
                    w_clear      = 1'b1;
                end
            end
            StUpload: begin
                if (w_upload_fall) begin
                    w_state_next = StHold;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_motor_d  <= 1'b0;
            r_upload_d <= 1'b0;
            r_primed   <= 1'b0;
            r_ptr      <= '0;
            r_overflow <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_rd_ok    <= 1'b0;
            r_din      <= CAS_PAD_BYTE;
        end else begin
            r_motor_d  <= cas_motor;
            r_upload_d <= ioctl_upload;
            r_primed   <= 1'b1;
            if (w_clear) begin
                r_ptr      <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_wr_en) begin
                    r_ptr <= r_ptr + PtrOne;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
            r_rd_pend <= ioctl_rd;
            r_rd_ok   <= w_rd_ok;
            if (r_rd_pend) begin
                r_din <= r_rd_ok ? w_ram_q : CAS_PAD_BYTE;
            end
        end
    end

    ht1080z_cas_ram #(
        .AW (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (clk_sys),
        .i_we    (w_wr_en),
        .i_waddr (r_ptr[DEPTH_LOG2-1:0]),
        .i_wdata (cas_byte),
        .i_re    (ioctl_rd),
        .i_raddr (ioctl_addr[DEPTH_LOG2-1:0]),
        .o_rdata (w_ram_q)
    );

    assign ioctl_din  = r_din;
    assign rec_active = (r_state == StRecord);
    assign tape_ready = (r_state == StHold);
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_ht1080z_cas_upload.sv
// Bench for ht1080z_cas_upload: a 16-byte and a default-depth instance share stimulus
// and are checked against a tape-recorder model, a directed table and corner sequences.
module tb_ht1080z_cas_upload;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        cas_motor;
    logic [7:0]  cas_byte;
    logic        cas_byte_valid;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [15:0] ioctl_addr;
    logic [7:0]  din_a, din_b;
    logic [15:0] len_a, len_b;
    logic        rec_a, rec_b, ovf_a, ovf_b, rdy_a, rdy_b;

    always #5 clk_sys = ~clk_sys;

    ht1080z_cas_upload #(.DEPTH_LOG2(4)) u_dut_a (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .cas_motor      (cas_motor),
        .cas_byte       (cas_byte),
        .cas_byte_valid (cas_byte_valid),
        .ioctl_upload   (ioctl_upload),
        .ioctl_rd       (ioctl_rd),
        .ioctl_addr     (ioctl_addr),
        .ioctl_din      (din_a),
        .cas_len        (len_a),
        .rec_active     (rec_a),
        .overflow       (ovf_a),
        .tape_ready     (rdy_a)
    );

    ht1080z_cas_upload u_dut_b (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .cas_motor      (cas_motor),
        .cas_byte       (cas_byte),
        .cas_byte_valid (cas_byte_valid),
        .ioctl_upload   (ioctl_upload),
        .ioctl_rd       (ioctl_rd),
        .ioctl_addr     (ioctl_addr),
        .ioctl_din      (din_b),
        .cas_len        (len_b),
        .rec_active     (rec_b),
        .overflow       (ovf_b),
        .tape_ready     (rdy_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: tape deck modes, recorded length, and a list of pending read replies.
    localparam int MIdle = 0, MRec = 1, MHold = 2, MUp = 3;
    int         m_st   [2];
    int         m_len  [2];
    bit         m_ovf  [2];
    bit         m_mprev[2];
    bit         m_uprev[2];
    logic [7:0] m_din  [2];
    logic [7:0] m_mem  [2][32768];
    int         cyc_n = 0;

    typedef struct {
        int         due;
        logic [7:0] v0;
        logic [7:0] v1;
    } rd_t;
    rd_t rq[$];

    typedef struct {
        logic        mo;
        logic        v;
        logic [7:0]  b;
        logic        up;
        logic        rd;
        logic [15:0] a;
        logic        rec;
        logic        rdy;
        logic [15:0] len;
        logic [7:0]  din;
    } vec_t;
    vec_t tbl[13];

    function automatic int depth(int m);
        return (m == 0) ? 16 : 32768;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_st[m]    = MIdle;
            m_len[m]   = 0;
            m_ovf[m]   = 1'b0;
            m_mprev[m] = 1'b1;  // first sample after reset can never be a rising edge
            m_uprev[m] = 1'b1;
            m_din[m]   = 8'h00;
        end
        rq.delete();
    endtask

    task automatic model_edge();
        logic [7:0] rv[2];
        rd_t        r;
        for (int m = 0; m < 2; m++) begin
            bit mr, mf, ur, uf;
            mr = cas_motor && !m_mprev[m];
            mf = !cas_motor && m_mprev[m];
            ur = ioctl_upload && !m_uprev[m];
            uf = !ioctl_upload && m_uprev[m];
            rv[m] = (m_st[m] == MUp && int'(ioctl_addr) < m_len[m]) ?
                    m_mem[m][ioctl_addr] : 8'h00;
            case (m_st[m])
                MIdle: if (mr) begin m_st[m] = MRec; m_len[m] = 0; m_ovf[m] = 1'b0; end
                MRec: begin
                    if (cas_byte_valid) begin
                        if (m_len[m] < depth(m)) begin
                            m_mem[m][m_len[m]] = cas_byte;
                            m_len[m]++;
                        end else begin
                            m_ovf[m] = 1'b1;
                        end
                    end
                    if (mf) m_st[m] = (m_len[m] > 0) ? MHold : MIdle;
                end
                MHold: begin
                    if (ur) m_st[m] = MUp;
                    else if (mr) begin m_st[m] = MRec; m_len[m] = 0; m_ovf[m] = 1'b0; end
                end
                default: if (uf) m_st[m] = MHold;
            endcase
            m_mprev[m] = cas_motor;
            m_uprev[m] = ioctl_upload;
        end
        cyc_n++;
        while (rq.size() > 0 && rq[0].due == cyc_n) begin
            m_din[0] = rq[0].v0;
            m_din[1] = rq[0].v1;
            void'(rq.pop_front());
        end
        if (ioctl_rd) begin
            r.due = cyc_n + 1;
            r.v0  = rv[0];
            r.v1  = rv[1];
            rq.push_back(r);
        end
    endtask

    task automatic check_all();
        chk("a_rec", 16'(rec_a), 16'(m_st[0] == MRec));
        chk("a_rdy", 16'(rdy_a), 16'(m_st[0] == MHold));
        chk("a_len", len_a, 16'(m_len[0]));
        chk("a_ovf", 16'(ovf_a), 16'(m_ovf[0]));
        chk("a_din", 16'(din_a), 16'(m_din[0]));
        chk("b_rec", 16'(rec_b), 16'(m_st[1] == MRec));
        chk("b_rdy", 16'(rdy_b), 16'(m_st[1] == MHold));
        chk("b_len", len_b, 16'(m_len[1]));
        chk("b_ovf", 16'(ovf_b), 16'(m_ovf[1]));
        chk("b_din", 16'(din_b), 16'(m_din[1]));
    endtask

    task automatic cyc(input logic mo, input logic v, input logic [7:0] b,
                       input logic up, input logic rd, input logic [15:0] a);
        cas_motor      = mo;
        cas_byte_valid = v;
        cas_byte       = b;
        ioctl_upload   = up;
        ioctl_rd       = rd;
        ioctl_addr     = a;
        @(posedge clk_sys);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1;
        check_all();
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    initial begin
        logic mo, up;
        reset_n        = 1'b0;
        cas_motor      = 1'b0;
        cas_byte       = 8'h00;
        cas_byte_valid = 1'b0;
        ioctl_upload   = 1'b0;
        ioctl_rd       = 1'b0;
        ioctl_addr     = 16'h0;
        model_reset();
        repeat (2) @(posedge clk_sys);
        #1;
        check_all();
        @(negedge clk_sys);
        reset_n = 1'b1;
        cyc(0, 0, 8'h00, 0, 0, 16'h0);

        //             mo   v    byte   up   rd   addr      rec  rdy  len    din
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd1, 8'h00};
        tbl[2]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd2, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd3, 8'h00};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd3, 8'h00};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 16'd3, 8'h00};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 16'd3, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'd1, 1'b0, 1'b0, 16'd3, 8'h55};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'd2, 1'b0, 1'b0, 16'd3, 8'hA5};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'd3, 1'b0, 1'b0, 16'd3, 8'h3C};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 16'd3, 8'h00};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 16'd3, 8'h00};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd3, 8'h00};
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].mo, tbl[i].v, tbl[i].b, tbl[i].up, tbl[i].rd, tbl[i].a);
            chk($sformatf("tbl%0d_rec", i), 16'(rec_b), 16'(tbl[i].rec));
            chk($sformatf("tbl%0d_rdy", i), 16'(rdy_b), 16'(tbl[i].rdy));
            chk($sformatf("tbl%0d_len", i), len_b, tbl[i].len);
            chk($sformatf("tbl%0d_din", i), 16'(din_b), 16'(tbl[i].din));
            chk($sformatf("tbl%0d_din_a", i), 16'(din_a), 16'(tbl[i].din));
        end

        // Overflow in the 16-byte instance, then cleared by a new recording.
        cyc(1, 0, 8'h00, 0, 0, 16'h0);
        chk("ovf_start_len", len_a, 16'd0);
        for (int i = 0; i < 20; i++) cyc(1, 1, 8'(i + 8'h10), 0, 0, 16'h0);
        chk("ovf_len_a", len_a, 16'd16);
        chk("ovf_flag_a", 16'(ovf_a), 16'd1);
        chk("ovf_len_b", len_b, 16'd20);
        chk("ovf_flag_b", 16'(ovf_b), 16'd0);
        cyc(0, 0, 8'h00, 0, 0, 16'h0);
        cyc(1, 0, 8'h00, 0, 0, 16'h0);
        chk("ovf_clr_flag", 16'(ovf_a), 16'd0);
        chk("ovf_clr_len", len_a, 16'd0);

        // Empty recording falls back to idle.
        cyc(0, 0, 8'h00, 0, 0, 16'h0);
        chk("empty_rdy", 16'(rdy_a), 16'd0);
        chk("empty_rec", 16'(rec_a), 16'd0);

        // Byte coincident with motor falling is kept.
        cyc(1, 0, 8'h00, 0, 0, 16'h0);
        cyc(1, 1, 8'hAA, 0, 0, 16'h0);
        cyc(0, 1, 8'hBB, 0, 0, 16'h0);
        chk("coinc_len", len_a, 16'd2);
        chk("coinc_rdy", 16'(rdy_a), 16'd1);
        cyc(0, 0, 8'h00, 1, 0, 16'h0);
        cyc(0, 0, 8'h00, 1, 1, 16'd1);
        cyc(0, 0, 8'h00, 1, 1, 16'd17);
        chk("coinc_rd1", 16'(din_a), 16'hBB);
        cyc(0, 0, 8'h00, 1, 0, 16'h0);
        chk("alias_rd17", 16'(din_a), 16'h00);

        // Motor activity during upload is ignored.
        cyc(1, 1, 8'h77, 1, 0, 16'h0);
        cyc(1, 1, 8'h78, 1, 1, 16'd0);
        cyc(1, 1, 8'h79, 1, 0, 16'h0);
        chk("up_motor_len", len_a, 16'd2);
        chk("up_motor_rd0", 16'(din_a), 16'hAA);
        cyc(1, 0, 8'h00, 0, 0, 16'h0);
        chk("up_exit_rdy", 16'(rdy_a), 16'd1);
        cyc(1, 0, 8'h00, 0, 0, 16'h0);
        chk("up_exit_norec", 16'(rec_a), 16'd0);
        cyc(0, 0, 8'h00, 0, 0, 16'h0);
        cyc(1, 0, 8'h00, 0, 0, 16'h0);
        chk("up_exit_rec", 16'(rec_a), 16'd1);
        chk("up_exit_len", len_a, 16'd0);

        // Reset mid-recording with the motor still high.
        for (int i = 0; i < 5; i++) cyc(1, 1, 8'(8'hC0 + i), 0, 0, 16'h0);
        chk("pre_rst_len", len_a, 16'd5);
        @(negedge clk_sys);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_rec", 16'(rec_a), 16'd0);
        chk("rst_len", len_a, 16'd0);
        chk("rst_din", 16'(din_a), 16'd0);
        check_all();
        @(posedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        cyc(1, 1, 8'hEE, 0, 0, 16'h0);
        cyc(1, 1, 8'hEF, 0, 0, 16'h0);
        chk("rst_motor_high", 16'(rec_a), 16'd0);
        cyc(1, 0, 8'h00, 1, 0, 16'h0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'h00, 1, 1, 16'(i));
        cyc(1, 0, 8'h00, 1, 0, 16'h0);
        chk("rst_upload_rd", 16'(din_b), 16'h00);
        cyc(0, 0, 8'h00, 0, 0, 16'h0);

        // Random traffic against the model.
        mo = 1'b0;
        up = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) mo = ~mo;
            if ($urandom_range(0, 14) == 0) up = ~up;
            cyc(mo, 1'($urandom_range(0, 1)), 8'($urandom), up,
                1'($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 24)));
            if (i % 1500 == 700) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
